// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache refill path
// and the D-cache refill/write-back path. Grants one side at a time, runs a
// BLOCK_WORDS-word block transfer, then pulses done for the owner.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin tie-break between the
// two sides (default build: data side always wins a tie).
module mem_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int BEAT_W      = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    // instruction side
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    // data side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [BEAT_W-1:0] d_beat,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    // memory side
    output logic              m_req,
    output logic              m_we,
    output logic [31:0]       m_addr,
    output logic [31:0]       m_wdata,
    input  logic              m_ack,
    input  logic [31:0]       m_rdata
);

    // Byte-offset bits inside one aligned block; cleared to form the base.
    localparam logic [31:0]       LOW_MASK  = 32'(BLOCK_WORDS * 4 - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t            state, state_n;
    logic [31:0]       base, base_n;
    logic [BEAT_W-1:0] beat, beat_n, d_beat_n;
    logic              i_gnt_n, d_gnt_n, i_rvalid_n, d_rvalid_n;
    logic              i_done_n, d_done_n, m_req_n, m_we_n;
    logic [31:0]       i_rdata_n, d_rdata_n;
    logic              pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data side was granted last; reset to instruction-last so data
    // wins the first tie.
    logic last_d, last_d_n;

    // Tie goes to the side that was not granted last.
    always_comb begin
        pick_d   = d_req && (!i_req || !last_d);
        last_d_n = last_d;
        if (state == IDLE && (i_req || d_req))
            last_d_n = pick_d;
    end

    // Last-grant register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_d <= 1'b0;
        else        last_d <= last_d_n;
    end
`else
    // Fixed priority: data side always beats instruction side.
    always_comb pick_d = d_req;
`endif

    // Memory address walks the aligned block; zero when no access is open.
    always_comb begin
        m_addr = '0;
        if (m_req)
            m_addr = base | {{(30 - BEAT_W){1'b0}}, beat, 2'b00};
    end

    // Write data is passed straight through from the data cache while writing.
    always_comb begin
        m_wdata = '0;
        if (m_req && m_we)
            m_wdata = d_wdata;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n    = state;
        base_n     = base;
        beat_n     = beat;
        i_gnt_n    = i_gnt;
        d_gnt_n    = d_gnt;
        i_rvalid_n = 1'b0;
        d_rvalid_n = 1'b0;
        i_rdata_n  = i_rdata;
        d_rdata_n  = d_rdata;
        i_done_n   = 1'b0;
        d_done_n   = 1'b0;
        m_req_n    = m_req;
        m_we_n     = m_we;
        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_n = XFER;
                    d_gnt_n = pick_d;
                    i_gnt_n = !pick_d;
                    base_n  = (pick_d ? d_addr : i_addr) & ~LOW_MASK;
                    beat_n  = '0;
                    m_req_n = 1'b1;
                    m_we_n  = pick_d && d_we;
                end
            end
            XFER: begin
                if (m_ack) begin
                    beat_n = beat + BEAT_W'(1);
                    if (!m_we) begin
                        if (d_gnt) begin
                            d_rvalid_n = 1'b1;
                            d_rdata_n  = m_rdata;
                        end else begin
                            i_rvalid_n = 1'b1;
                            i_rdata_n  = m_rdata;
                        end
                    end
                    if (beat == LAST_BEAT) begin
                        state_n  = RESP;
                        m_req_n  = 1'b0;
                        m_we_n   = 1'b0;
                        i_done_n = i_gnt;
                        d_done_n = d_gnt;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
                i_gnt_n = 1'b0;
                d_gnt_n = 1'b0;
                beat_n  = '0;
            end
            default: state_n = IDLE;
        endcase
        d_beat_n = d_gnt_n ? beat_n : '0;
    end

    // State and output registers; reset aborts any transfer without done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            base     <= '0;
            beat     <= '0;
            d_beat   <= '0;
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
        end else begin
            state    <= state_n;
            base     <= base_n;
            beat     <= beat_n;
            d_beat   <= d_beat_n;
            i_gnt    <= i_gnt_n;
            d_gnt    <= d_gnt_n;
            i_rvalid <= i_rvalid_n;
            d_rvalid <= d_rvalid_n;
            i_rdata  <= i_rdata_n;
            d_rdata  <= d_rdata_n;
            i_done   <= i_done_n;
            d_done   <= d_done_n;
            m_req    <= m_req_n;
            m_we     <= m_we_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (BLOCK_WORDS = 4). Inputs change and outputs
// are sampled 1 ns after the rising edge.
module tb_mem_arbiter;

    localparam int BW = 4;

    logic          clk;
    logic          reset;
    logic          i_req, d_req, d_we, m_ack;
    logic [31:0]   i_addr, d_addr, d_wdata, m_rdata;
    logic          i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done;
    logic [31:0]   i_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]    d_beat;
    logic          m_req, m_we;
    logic          wb_mode;

    int vectors     = 0;
    int miscompares = 0;

    mem_arbiter #(.BLOCK_WORDS(BW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_beat(d_beat), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data cache model: write word depends on the current beat.
    assign d_wdata = wb_mode ? (32'hA0 + {30'd0, d_beat}) : 32'h0;
    // Memory model: read word tagged with the low half of the address.
    assign m_rdata = {16'hBEEF, m_addr[15:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grants must be mutually exclusive at all times.
    always @(negedge clk)
        if (reset) chk("gnt_excl", {31'd0, i_gnt & d_gnt}, 32'd0);

    initial begin
        reset = 1'b0; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
        i_addr = '0; d_addr = '0; wb_mode = 0;
        step();
        chk("rst_ctl", {24'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done, m_req, m_we}, 32'd0);
        chk("rst_irdata", i_rdata, 32'd0);
        chk("rst_drdata", d_rdata, 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_mwdata", m_wdata, 32'd0);
        chk("rst_dbeat", {30'd0, d_beat}, 32'd0);
        reset = 1'b1;
        step();

        // 1: instruction read, unaligned address, m_ack tied high
        m_ack = 1; i_req = 1; i_addr = 32'h0000_104C;
        step();
        chk("i_gnt", {31'd0, i_gnt}, 32'd1);
        chk("i_mreq", {31'd0, m_req}, 32'd1);
        chk("i_rvalid0", {31'd0, i_rvalid}, 32'd0);
        for (int k = 0; k < BW; k++) begin
            chk("i_maddr", m_addr, 32'h1040 + 32'(4 * k));
            chk("i_mwe", {31'd0, m_we}, 32'd0);
            chk("i_done_early", {31'd0, i_done}, 32'd0);
            chk("i_dbeat", {30'd0, d_beat}, 32'd0);
            step();
            chk("i_rvalid", {31'd0, i_rvalid}, 32'd1);
            chk("i_rdata", i_rdata, 32'hBEEF_1040 + 32'(4 * k));
        end
        // RESP cycle: 5th cycle of the grant
        chk("i_done", {31'd0, i_done}, 32'd1);
        chk("i_gnt_resp", {31'd0, i_gnt}, 32'd1);
        chk("i_mreq_resp", {31'd0, m_req}, 32'd0);
        chk("i_drvalid", {31'd0, d_rvalid}, 32'd0);
        i_req = 0;
        step();
        chk("i_idle", {29'd0, i_gnt, i_done, i_rvalid}, 32'd0);
        chk("i_idle_maddr", m_addr, 32'd0);

        // 2: data write-back, m_ack every other cycle
        m_ack = 0; wb_mode = 1; d_req = 1; d_we = 1; d_addr = 32'h0000_2000;
        step();
        chk("wb_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
        for (int k = 0; k < BW; k++) begin
            chk("wb_mwe", {31'd0, m_we}, 32'd1);
            chk("wb_dbeat", {30'd0, d_beat}, 32'(k));
            chk("wb_maddr", m_addr, 32'h2000 + 32'(4 * k));
            chk("wb_mwdata", m_wdata, 32'hA0 + 32'(k));
            step();
            chk("wb_mwdata_hold", m_wdata, 32'hA0 + 32'(k));
            chk("wb_ddone_early", {31'd0, d_done}, 32'd0);
            m_ack = 1;
            step();
            m_ack = 0;
            chk("wb_drvalid", {31'd0, d_rvalid}, 32'd0);
        end
        chk("wb_ddone", {31'd0, d_done}, 32'd1);
        chk("wb_mreq_resp", {31'd0, m_req}, 32'd0);
        d_req = 0; d_we = 0; wb_mode = 0;
        step();
        chk("wb_idle", {29'd0, d_gnt, d_done, d_rvalid}, 32'd0);
        chk("wb_dbeat_idle", {30'd0, d_beat}, 32'd0);

        // 3: simultaneous requests, twice
        m_ack = 1; i_req = 1; d_req = 1; i_addr = 32'h3000; d_addr = 32'h4000;
        step();
        chk("tie1_gnt", {30'd0, i_gnt, d_gnt}, 32'b01);
        repeat (BW) step();
        chk("tie1_ddone", {31'd0, d_done}, 32'd1);
        chk("tie1_drdata", d_rdata, 32'hBEEF_400C);
        d_req = 0;
        step();
        d_req = 1;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        chk("tie2_gnt", {30'd0, i_gnt, d_gnt}, 32'b10);
        repeat (BW) step();
        chk("tie2_idone", {30'd0, i_done, d_done}, 32'b10);
`else
        chk("tie2_gnt", {30'd0, i_gnt, d_gnt}, 32'b01);
        repeat (BW) step();
        chk("tie2_ddone", {30'd0, i_done, d_done}, 32'b01);
`endif
        i_req = 0; d_req = 0;
        step();

        // 4: reset during beat 2, then a fresh request
        i_req = 1; i_addr = 32'h5000;
        step();
        step();
        step();
        chk("rst_mid_maddr", m_addr, 32'h5008);
        #1 reset = 1'b0; i_req = 0;
        #1;
        chk("rst_async_ctl", {24'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done, m_req, m_we}, 32'd0);
        chk("rst_async_maddr", m_addr, 32'd0);
        chk("rst_async_irdata", i_rdata, 32'd0);
        step();
        chk("rst_no_done", {30'd0, i_done, d_done}, 32'd0);
        reset = 1'b1;
        step();
        i_req = 1; i_addr = 32'h6008;
        step();
        chk("post_rst_gnt", {31'd0, i_gnt}, 32'd1);
        for (int k = 0; k < BW; k++) begin
            chk("post_rst_maddr", m_addr, 32'h6000 + 32'(4 * k));
            step();
        end
        chk("post_rst_done", {31'd0, i_done}, 32'd1);
        chk("post_rst_rdata", i_rdata, 32'hBEEF_600C);
        i_req = 0;
        step();

        // 5: requester drops req after beat 1; transfer still completes
        d_req = 1; d_we = 0; d_addr = 32'h7004;
        step();
        chk("drop_gnt", {31'd0, d_gnt}, 32'd1);
        chk("drop_maddr0", m_addr, 32'h7000);
        step();
        d_req = 0;
        step();
        step();
        chk("drop_maddr3", m_addr, 32'h700C);
        step();
        chk("drop_done", {31'd0, d_done}, 32'd1);
        chk("drop_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("drop_rdata", d_rdata, 32'hBEEF_700C);
        step();
        chk("drop_idle", {30'd0, d_gnt, d_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
